// File: rtl/grid_overlay_gen_pkg.sv
// ---------------------------------------------------------------------------
// grid_overlay_pkg
// Shared types and constants for the grid overlay stage and its helpers.
//   mode_e  : runtime overlay mode (bypass / frame / solid grid / dotted grid)
//   rgb_t   : one {R,G,B} pixel, 8 bits per channel
//   *_DEF   : default colours used when a block is elaborated without overrides
// ---------------------------------------------------------------------------
package grid_overlay_pkg;

  localparam int RGB_W = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_FRAME  = 2'd1,
    MODE_SOLID  = 2'd2,
    MODE_DOT    = 2'd3
  } mode_e;

  localparam rgb_t FRAME_COLOR_DEF = 24'h191970;
  localparam rgb_t GRID_COLOR_DEF  = 24'hFFFFFF;
  localparam rgb_t BLACK           = 24'h000000;

endpackage

// File: rtl/grid_overlay_gen_if.sv
// ---------------------------------------------------------------------------
// grid_overlay_gen_if
// Video stream plus runtime configuration seen by the grid overlay stage.
//   i_hs/i_vs/i_de/i_data : incoming video (syncs, data enable, pixel)
//   cfg_mode/cfg_grid_color : runtime settings, sampled at frame start
//   o_hs/o_vs/o_de/o_data : overlaid video, two pixel clocks behind
// master : the side that produces video/config and consumes the result
// slave  : the overlay stage itself
// ---------------------------------------------------------------------------
interface grid_overlay_gen_if #(
  parameter int DATA_W = 24
);

  logic              i_hs;
  logic              i_vs;
  logic              i_de;
  logic [DATA_W-1:0] i_data;
  logic [1:0]        cfg_mode;
  logic [DATA_W-1:0] cfg_grid_color;
  logic              o_hs;
  logic              o_vs;
  logic              o_de;
  logic [DATA_W-1:0] o_data;

  modport master (
    output i_hs, i_vs, i_de, i_data, cfg_mode, cfg_grid_color,
    input  o_hs, o_vs, o_de, o_data
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_data, cfg_mode, cfg_grid_color,
    output o_hs, o_vs, o_de, o_data
  );

endinterface

// File: rtl/grid_overlay_gen_video_xy_counter.sv
// ---------------------------------------------------------------------------
// video_xy_counter
// Pixel/line position tracker shared by the overlay blocks.
//   pclk, rst : pixel clock, asynchronous active-high reset
//   i_vs, i_de: incoming vertical sync and data enable
//   x, y      : coordinate of the pixel currently presented on the inputs
//               (x valid while i_de is high), both saturating
//   vs_rise   : i_vs rising edge seen this cycle (frame start)
//   de_fall   : i_de falling edge seen this cycle (end of an active line)
// ---------------------------------------------------------------------------
module video_xy_counter #(
  parameter int X_W = 12
) (
  input  logic           pclk,
  input  logic           rst,
  input  logic           i_vs,
  input  logic           i_de,
  output logic [X_W-1:0] x,
  output logic [X_W-1:0] y,
  output logic           vs_rise,
  output logic           de_fall
);

  localparam logic [X_W-1:0] CNT_MAX = {X_W{1'b1}};
  localparam logic [X_W-1:0] ONE     = X_W'(1);

  logic vs_q;
  logic de_q;

  assign vs_rise = i_vs & ~vs_q;
  assign de_fall = ~i_de & de_q;

  // Previous-cycle copies of vs/de for the edge detectors.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vs_q <= 1'b0;
      de_q <= 1'b0;
    end else begin
      vs_q <= i_vs;
      de_q <= i_de;
    end
  end

  // The register value is the column of the pixel on the inputs right now;
  // it is held at zero through blanking so the first active pixel is x = 0.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      x <= '0;
    end else if (!i_de) begin
      x <= '0;
    end else if (x != CNT_MAX) begin
      x <= x + ONE;
    end
  end

  // Line counter; a frame start overrides a coincident end-of-line.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      y <= '0;
    end else if (vs_rise) begin
      y <= '0;
    end else if (de_fall && (y != CNT_MAX)) begin
      y <= y + ONE;
    end
  end

endmodule

// File: rtl/grid_overlay_gen.sv
// ---------------------------------------------------------------------------
// grid_overlay_gen
// Draws a rectangular frame and an optional solid or dotted N x M grid onto
// a 24-bit RGB stream. Syncs, data enable and pixel data all leave exactly
// two pixel clocks after they arrive.
//   pclk : pixel clock
//   rst  : asynchronous active-high reset
//   vid  : video in/out and runtime configuration (slave side)
// Mode and grid colour are shadowed on the i_vs rising edge, so changes made
// mid-frame only show up in the following frame.
// ---------------------------------------------------------------------------
module grid_overlay_gen
  import grid_overlay_pkg::*;
#(
  parameter int                X_W         = 12,
  parameter int                DATA_W      = 24,
  parameter int                X0          = 449,
  parameter int                X1          = 1477,
  parameter int                Y0          = 32,
  parameter int                Y1          = 287,
  parameter int                H_DIV       = 8,
  parameter int                V_DIV       = 4,
  parameter logic [DATA_W-1:0] FRAME_COLOR = FRAME_COLOR_DEF,
  parameter mode_e             MODE_RST    = MODE_FRAME
) (
  input logic               pclk,
  input logic               rst,
  grid_overlay_gen_if.slave vid
);

  localparam int XP = (X1 - X0) / H_DIV;
  localparam int YP = (Y1 - Y0) / V_DIV;

  localparam logic [X_W-1:0] X0_C    = X_W'(X0);
  localparam logic [X_W-1:0] X1_C    = X_W'(X1);
  localparam logic [X_W-1:0] Y0_C    = X_W'(Y0);
  localparam logic [X_W-1:0] Y1_C    = X_W'(Y1);
  localparam logic [X_W-1:0] XP_LAST = X_W'(XP - 1);
  localparam logic [X_W-1:0] YP_LAST = X_W'(YP - 1);
  localparam logic [X_W-1:0] ONE     = X_W'(1);

  logic [X_W-1:0]    x;
  logic [X_W-1:0]    y;
  logic              vs_rise;
  logic              de_fall;
  logic [X_W-1:0]    xg;
  logic [X_W-1:0]    yg;
  mode_e             mode_act;
  logic [DATA_W-1:0] grid_color_act;

  logic x_in;
  logic y_in;
  logic frame_hit;
  logic vgrid;
  logic hgrid;
  logic frame_sel;
  logic grid_sel;

  logic              hs1;
  logic              vs1;
  logic              de1;
  logic [DATA_W-1:0] data1;
  logic              frame1;
  logic              grid1;

  video_xy_counter #(
    .X_W (X_W)
  ) u_xy (
    .pclk    (pclk),
    .rst     (rst),
    .i_vs    (vid.i_vs),
    .i_de    (vid.i_de),
    .x       (x),
    .y       (y),
    .vs_rise (vs_rise),
    .de_fall (de_fall)
  );

  // Column phase within a grid division, so no divider is needed. At x == X0
  // the register is stale, but that column is frame, never grid; from X0+1
  // on it holds (x - X0) mod XP.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      xg <= '0;
    end else if (vid.i_de) begin
      if (x == X0_C) begin
        xg <= ONE;
      end else if (xg == XP_LAST) begin
        xg <= '0;
      end else begin
        xg <= xg + ONE;
      end
    end
  end

  // Row phase, advanced at each end of line and restarted after the top edge.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      yg <= '0;
    end else if (de_fall) begin
      if (y == Y0_C) begin
        yg <= ONE;
      end else if (yg == YP_LAST) begin
        yg <= '0;
      end else begin
        yg <= yg + ONE;
      end
    end
  end

  // Runtime settings only take effect at a frame boundary.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      mode_act       <= MODE_RST;
      grid_color_act <= '0;
    end else if (vs_rise) begin
      mode_act       <= mode_e'(vid.cfg_mode);
      grid_color_act <= vid.cfg_grid_color;
    end
  end

  // Hit detection for the pixel currently on the inputs. Grid lines are kept
  // inside the frame rectangle; the dotted style thins vertical lines on even
  // rows and horizontal lines on even columns.
  always_comb begin
    x_in      = 1'b0;
    y_in      = 1'b0;
    frame_hit = 1'b0;
    vgrid     = 1'b0;
    hgrid     = 1'b0;
    frame_sel = 1'b0;
    grid_sel  = 1'b0;

    x_in      = (x >= X0_C) && (x <= X1_C);
    y_in      = (y >= Y0_C) && (y <= Y1_C);
    frame_hit = ((x == X0_C) || (x == X1_C) || (y == Y0_C) || (y == Y1_C)) && x_in && y_in;
    vgrid     = (x > X0_C) && (x < X1_C) && (xg == '0) && y_in;
    hgrid     = (y > Y0_C) && (y < Y1_C) && (yg == '0) && x_in;

    case (mode_act)
      MODE_SOLID: grid_sel = vgrid | hgrid;
      MODE_DOT:   grid_sel = (vgrid & y[0]) | (hgrid & x[0]);
      default:    grid_sel = 1'b0;
    endcase

    frame_sel = frame_hit && (mode_act != MODE_BYPASS) && vid.i_de;
    grid_sel  = grid_sel && vid.i_de;
  end

  // Stage 1: capture video and the hit decisions side by side.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hs1    <= 1'b0;
      vs1    <= 1'b0;
      de1    <= 1'b0;
      data1  <= '0;
      frame1 <= 1'b0;
      grid1  <= 1'b0;
    end else begin
      hs1    <= vid.i_hs;
      vs1    <= vid.i_vs;
      de1    <= vid.i_de;
      data1  <= vid.i_data;
      frame1 <= frame_sel;
      grid1  <= grid_sel;
    end
  end

  // Stage 2: colour mux, frame over grid over video.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vid.o_hs   <= 1'b0;
      vid.o_vs   <= 1'b0;
      vid.o_de   <= 1'b0;
      vid.o_data <= '0;
    end else begin
      vid.o_hs <= hs1;
      vid.o_vs <= vs1;
      vid.o_de <= de1;
      if (frame1) begin
        vid.o_data <= FRAME_COLOR;
      end else if (grid1) begin
        vid.o_data <= grid_color_act;
      end else begin
        vid.o_data <= data1;
      end
    end
  end

endmodule

// File: tb/tb_grid_overlay_gen.sv
// ---------------------------------------------------------------------------
// tb_grid_overlay_gen
// Scoreboard bench for grid_overlay_gen on a 16 x 8 test frame
// (X0=2, X1=10, Y0=1, Y1=5, XP=2, YP=2). The driver pushes the expected
// output of every driven cycle, tagged with the cycle it must appear in;
// an independent monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_grid_overlay_gen;
  import grid_overlay_pkg::*;

  localparam int X0    = 2;
  localparam int X1    = 10;
  localparam int Y0    = 1;
  localparam int Y1    = 5;
  localparam int H_DIV = 4;
  localparam int V_DIV = 2;
  localparam int XP    = (X1 - X0) / H_DIV;
  localparam int YP    = (Y1 - Y0) / V_DIV;
  localparam rgb_t FRAME_C = 24'h191970;
  localparam rgb_t GRID_C  = 24'hFFFFFF;
  localparam rgb_t ALT_C   = 24'h00FF00;

  typedef struct {
    int   due;
    logic hs;
    logic vs;
    logic de;
    rgb_t data;
  } exp_t;

  logic pclk;
  logic rst;
  int   cyc = 0;
  int   checkCount = 0;
  int   errorCount = 0;
  exp_t expQ[$];

  grid_overlay_gen_if #(.DATA_W(24)) vid ();

  grid_overlay_gen #(
    .X_W         (12),
    .DATA_W      (24),
    .X0          (X0),
    .X1          (X1),
    .Y0          (Y0),
    .Y1          (Y1),
    .H_DIV       (H_DIV),
    .V_DIV       (V_DIV),
    .FRAME_COLOR (FRAME_C),
    .MODE_RST    (MODE_FRAME)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .vid  (vid)
  );

  // Free-running pixel clock and a count of rising edges for scoreboard timing.
  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  // Expected overlay colour for a pixel at (mx, my), worked out from the
  // frame/grid geometry directly.
  function automatic rgb_t expPixel(input int mx, input int my, input int mode,
                                    input rgb_t gc, input rgb_t video);
    bit xin, yin, frameHit, vLine, hLine;
    xin      = (mx >= X0) && (mx <= X1);
    yin      = (my >= Y0) && (my <= Y1);
    frameHit = ((mx == X0) || (mx == X1) || (my == Y0) || (my == Y1)) && xin && yin;
    vLine    = (mx > X0) && (mx < X1) && (((mx - X0) % XP) == 0) && yin;
    hLine    = (my > Y0) && (my < Y1) && (((my - Y0) % YP) == 0) && xin;
    if (mode == MODE_DOT) begin
      vLine = vLine && ((my % 2) == 1);
      hLine = hLine && ((mx % 2) == 1);
    end
    if (mode == MODE_BYPASS) return video;
    if (frameHit) return FRAME_C;
    if (((mode == MODE_SOLID) || (mode == MODE_DOT)) && (vLine || hLine)) return gc;
    return video;
  endfunction

  task automatic checkOutput(input string name, input logic [26:0] act, input logic [26:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got hs/vs/de/data=%b/%b/%b/%h, expected %b/%b/%b/%h",
               name, act[26], act[25], act[24], act[23:0], exp[26], exp[25], exp[24], exp[23:0]);
    end
  endtask

  // Drive one cycle at the falling edge and queue what must come out two
  // rising edges later. A cycle driven while reset is held must produce zeros.
  task automatic applyStimulus(input logic hs, input logic vs, input logic de,
                               input rgb_t data, input rgb_t expData, input logic rstIn);
    exp_t e;
    @(negedge pclk);
    rst        = rstIn;
    vid.i_hs   = hs;
    vid.i_vs   = vs;
    vid.i_de   = de;
    vid.i_data = data;
    e.due = cyc + 2;
    if (rstIn) begin
      e.hs = 1'b0; e.vs = 1'b0; e.de = 1'b0; e.data = '0;
    end else begin
      e.hs = hs; e.vs = vs; e.de = de; e.data = expData;
    end
    expQ.push_back(e);
  endtask

  task automatic driveVsync();
    rgb_t d;
    for (int i = 0; i < 5; i++) begin
      d = 24'($urandom);
      applyStimulus(1'b0, (i < 3), 1'b0, d, d, 1'b0);
    end
  endtask

  // One line: four blanking cycles (hs in the first two), then 16 pixels.
  task automatic driveLine(input int my, input int mode, input rgb_t gc, input bit randVideo);
    rgb_t d;
    for (int i = 0; i < 4; i++) begin
      d = 24'($urandom);
      applyStimulus((i < 2), 1'b0, 1'b0, d, d, 1'b0);
    end
    for (int i = 0; i < 16; i++) begin
      d = randVideo ? 24'($urandom) : BLACK;
      applyStimulus(1'b0, 1'b0, 1'b1, d, expPixel(i, my, mode, gc, d), 1'b0);
    end
  endtask

  // Monitor: every falling edge, compare the outputs against the entry due now.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge pclk);
      while ((expQ.size() > 0) && (expQ[0].due <= cyc)) begin
        e = expQ.pop_front();
        if (e.due == cyc) begin
          checkOutput($sformatf("stream cyc%0d", cyc),
                      {vid.o_hs, vid.o_vs, vid.o_de, vid.o_data},
                      {e.hs, e.vs, e.de, e.data});
        end else begin
          checkOutput($sformatf("late entry due%0d", e.due), 27'd0, 27'd1);
        end
      end
    end
  end

  // Watchdog so the run always ends on its own.
  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected normal completion");
    errorCount++;
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin : stimulus
    rgb_t d;
    int   waitCycles;
    rst                = 1'b1;
    vid.i_hs           = 1'b0;
    vid.i_vs           = 1'b0;
    vid.i_de           = 1'b0;
    vid.i_data         = '0;
    vid.cfg_mode       = MODE_FRAME;
    vid.cfg_grid_color = GRID_C;

    repeat (2) @(negedge pclk);
    #1 checkOutput("reset_state", {vid.o_hs, vid.o_vs, vid.o_de, vid.o_data}, 27'd0);
    $display("[TB] reset released");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, BLACK, BLACK, 1'b0);

    // Frame only.
    vid.cfg_mode = MODE_FRAME;
    driveVsync();
    for (int y = 0; y < 8; y++) driveLine(y, MODE_FRAME, GRID_C, 1'b0);

    // Solid grid.
    vid.cfg_mode = MODE_SOLID;
    driveVsync();
    for (int y = 0; y < 8; y++) driveLine(y, MODE_SOLID, GRID_C, 1'b0);

    // Dotted grid; a mid-frame colour change must not show in this frame.
    vid.cfg_mode = MODE_DOT;
    driveVsync();
    for (int y = 0; y < 4; y++) driveLine(y, MODE_DOT, GRID_C, 1'b0);
    vid.cfg_grid_color = ALT_C;
    for (int y = 4; y < 8; y++) driveLine(y, MODE_DOT, GRID_C, 1'b0);
    vid.cfg_grid_color = GRID_C;

    // Mode written 1 -> 2 at line 3: no grid until the next frame.
    vid.cfg_mode = MODE_FRAME;
    driveVsync();
    for (int y = 0; y < 3; y++) driveLine(y, MODE_FRAME, GRID_C, 1'b0);
    vid.cfg_mode = MODE_SOLID;
    for (int y = 3; y < 8; y++) driveLine(y, MODE_FRAME, GRID_C, 1'b0);
    driveVsync();
    for (int y = 0; y < 8; y++) driveLine(y, MODE_SOLID, GRID_C, 1'b0);

    // Reset in the middle of line 4 of a dotted frame.
    vid.cfg_mode = MODE_DOT;
    driveVsync();
    for (int y = 0; y < 4; y++) driveLine(y, MODE_DOT, GRID_C, 1'b0);
    for (int i = 0; i < 4; i++) begin
      d = 24'($urandom);
      applyStimulus((i < 2), 1'b0, 1'b0, d, d, 1'b0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, BLACK, expPixel(i, 4, MODE_DOT, GRID_C, BLACK), 1'b0);
    #2 rst = 1'b1;
    expQ.delete();
    #1 checkOutput("reset_async", {vid.o_hs, vid.o_vs, vid.o_de, vid.o_data}, 27'd0);
    vid.cfg_mode = MODE_SOLID;
    for (int i = 6; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, BLACK, BLACK, 1'b1);
    // After release the counters restart: remaining pixels are x=0.., row 0,
    // and the mode is the reset mode (frame only) until the next frame.
    for (int i = 8; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b1, BLACK, expPixel(i - 8, 0, MODE_FRAME, GRID_C, BLACK), 1'b0);
    for (int y = 5; y < 8; y++) driveLine(y - 4, MODE_FRAME, GRID_C, 1'b0);
    vid.cfg_mode = MODE_FRAME;
    driveVsync();
    for (int y = 0; y < 8; y++) driveLine(y, MODE_FRAME, GRID_C, 1'b0);

    // Bypass with random video everywhere.
    vid.cfg_mode = MODE_BYPASS;
    driveVsync();
    for (int y = 0; y < 8; y++) driveLine(y, MODE_BYPASS, GRID_C, 1'b1);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, BLACK, BLACK, 1'b0);
    waitCycles = 0;
    while ((expQ.size() > 0) && (waitCycles < 10)) begin
      @(negedge pclk);
      waitCycles++;
    end
    #1;
    if (expQ.size() > 0) begin
      checkOutput("drain", 27'(expQ.size()), 27'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
